rmt_axis_pkt_arb: RTL and testbench

- Packet-atomic AXI-Stream arbiter in front of the RMT pipeline input.
- Merges NUM_CH independent 512-bit AXIS sources into one stream, e.g. control/table-config packets plus multiple data ports.
- Round-robin grant, held for a whole packet (through the tlast beat), so control and data packets never interleave.
- Registered output stage with full tready backpressure.

---
 rtl/rmt_arb_pkg.sv | 41 ++++
 rtl/rmt_rr_sel.sv | 44 ++++
 rtl/rmt_axis_pkt_arb.sv | 162 ++++++++++++++++
 tb/tb_rmt_axis_pkt_arb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmt_arb_pkg.sv
// ---------------------------------------------------------------------------
// rmt_arb_pkg
// Shared definitions for the RMT packet-atomic AXIS arbiter:
//   - arbiter FSM state encoding (IDLE / FWD)
//   - rr_first_one(): circular first-one search used by the grant selector
// ---------------------------------------------------------------------------
package rmt_arb_pkg;

  // Upper bound on channel count supported by the search helper.
  localparam int MAX_CH   = 16;
  localparam int MAX_CH_W = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_FWD  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    FWD  = ST_FWD
  } arb_state_e;

  // Returns {found, index}: the first set bit of req[0..n-1] when scanning
  // ptr, ptr+1, ... wrapping at n. Requires ptr < n <= MAX_CH.
  function automatic logic [MAX_CH_W:0] rr_first_one(
    input logic [MAX_CH-1:0]   req,
    input logic [MAX_CH_W-1:0] ptr,
    input int                  n
  );
    logic [MAX_CH_W:0] res;
    logic [MAX_CH_W:0] idx;
    res = '0;
    for (int k = 0; k < MAX_CH; k++) begin
      idx = {1'b0, ptr} + (MAX_CH_W+1)'(k);
      if (idx >= (MAX_CH_W+1)'(n)) idx = idx - (MAX_CH_W+1)'(n);
      if ((k < n) && !res[MAX_CH_W] && req[idx[MAX_CH_W-1:0]]) begin
        res = {1'b1, idx[MAX_CH_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rmt_rr_sel.sv
// ---------------------------------------------------------------------------
// rmt_rr_sel
// Combinational circular priority encoder for the packet arbiter.
//   req     [NUM_CH] : per-channel requests (s_axis_tvalid)
//   ptr     [CH_W]   : round-robin start position
//   prio0   [1]      : when set, channel 0 wins outright and the round-robin
//                      search covers only channels 1..NUM_CH-1
//   gnt_idx [CH_W]   : selected channel
//   gnt_vld [1]      : at least one request present
// ---------------------------------------------------------------------------
module rmt_rr_sel
  import rmt_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  input  logic              prio0,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_vld
);

  logic [MAX_CH-1:0]   req_rr;
  logic [MAX_CH_W:0]   hit;
  logic                unused_hit_bits;

  always_comb begin
    req_rr = MAX_CH'(req);
    // Channel 0 is handled by the priority override, keep it out of the
    // round-robin scan so the remaining channels share fairly.
    if (prio0) req_rr[0] = 1'b0;
    hit     = rr_first_one(req_rr, MAX_CH_W'(ptr), NUM_CH);
    gnt_vld = hit[MAX_CH_W];
    gnt_idx = hit[CH_W-1:0];
    if (prio0 && req[0]) begin
      gnt_vld = 1'b1;
      gnt_idx = '0;
    end
  end

  assign unused_hit_bits = ^hit;

endmodule

// File: rtl/rmt_axis_pkt_arb.sv
// ---------------------------------------------------------------------------
// rmt_axis_pkt_arb
// Packet-atomic AXI-Stream arbiter in front of the RMT pipeline input.
// Merges NUM_CH AXIS sources into one stream; a grant is held from the first
// beat through tlast, so packets never interleave. Output is a one-entry
// register with full tready backpressure.
//
// Optional build macro: RMT_ARB_CTRL_PRIO_EN
//   defined   : channel 0 (control) has strict priority at each arbitration;
//               channels 1..NUM_CH-1 round-robin, pointer only moves after a
//               non-zero-channel packet.
//   undefined : pure round-robin over all channels.
//
// Ports:
//   clk, aresetn             clock, asynchronous active-low reset
//   s_axis_tdata/tkeep/tuser flattened per channel, channel i at [i*W +: W]
//   s_axis_tvalid/tlast      per-channel valid / last
//   s_axis_tready            per-channel ready (only the granted channel)
//   m_axis_*                 merged output stream (registered)
//   cur_grant                channel owning the output
//   pkt_cnt                  packets forwarded, wraps at 2^32
// ---------------------------------------------------------------------------
module rmt_axis_pkt_arb
  import rmt_arb_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_CH               = 4,
  parameter int CH_W                 = $clog2(NUM_CH)
) (
  input  logic                                      clk,
  input  logic                                      aresetn,
  input  logic [NUM_CH*C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_CH*C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [NUM_CH*C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic [NUM_CH-1:0]                         s_axis_tvalid,
  input  logic [NUM_CH-1:0]                         s_axis_tlast,
  output logic [NUM_CH-1:0]                         s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]          m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                                      m_axis_tvalid,
  output logic                                      m_axis_tlast,
  input  logic                                      m_axis_tready,
  output logic [CH_W-1:0]                           cur_grant,
  output logic [31:0]                               pkt_cnt
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH/8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

`ifdef RMT_ARB_CTRL_PRIO_EN
  localparam logic PRIO0 = 1'b1;
`else
  localparam logic PRIO0 = 1'b0;
`endif

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_next;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_vld;
  logic              out_free;

  // Stage 0: granted channel's beat and handshake
  logic [DW-1:0]     data_p0;
  logic [KW-1:0]     keep_p0;
  logic [UW-1:0]     user_p0;
  logic              last_p0;
  logic              acc_p0;

  // Stage 1: output register
  logic [DW-1:0]     data_p1;
  logic [KW-1:0]     keep_p1;
  logic [UW-1:0]     user_p1;
  logic              last_p1;
  logic              vld_p1;

  rmt_rr_sel #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_sel (
    .req     (s_axis_tvalid),
    .ptr     (rr_ptr),
    .prio0   (PRIO0),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign out_free = !vld_p1 || m_axis_tready;
  assign rr_next  = (cur_grant == CH_W'(NUM_CH-1)) ? '0 : cur_grant + 1'b1;

  assign data_p0 = s_axis_tdata[int'(cur_grant)*DW +: DW];
  assign keep_p0 = s_axis_tkeep[int'(cur_grant)*KW +: KW];
  assign user_p0 = s_axis_tuser[int'(cur_grant)*UW +: UW];
  assign last_p0 = s_axis_tlast[cur_grant];
  assign acc_p0  = (state_q == FWD) && out_free && s_axis_tvalid[cur_grant];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // IDLE spends one cycle registering the grant, so a freshly granted
  // channel never sees tready in the cycle the decision is made.
  always_comb begin
    state_d       = state_q;
    s_axis_tready = '0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) state_d = FWD;
      end
      FWD: begin
        if (out_free) s_axis_tready[cur_grant] = 1'b1;
        if (acc_p0 && last_p0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cur_grant <= '0;
      rr_ptr    <= '0;
      pkt_cnt   <= '0;
      vld_p1    <= 1'b0;
    end else begin
      if ((state_q == IDLE) && gnt_vld) cur_grant <= gnt_idx;
      if (acc_p0)        vld_p1 <= 1'b1;
      else if (out_free) vld_p1 <= 1'b0;
      if (acc_p0 && last_p0) begin
        pkt_cnt <= pkt_cnt + 32'd1;
        // Control-channel packets do not move the pointer in priority mode,
        // so they cannot skew fairness among the data channels.
        if (!(PRIO0 && (cur_grant == '0))) rr_ptr <= rr_next;
      end
    end
  end

  // Stage 1 boundary: output register loads on every accepted beat
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      data_p1 <= '0;
      keep_p1 <= '0;
      user_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (acc_p0) begin
      data_p1 <= data_p0;
      keep_p1 <= keep_p0;
      user_p1 <= user_p0;
      last_p1 <= last_p0;
    end
  end

  assign m_axis_tdata  = data_p1;
  assign m_axis_tkeep  = keep_p1;
  assign m_axis_tuser  = user_p1;
  assign m_axis_tlast  = last_p1;
  assign m_axis_tvalid = vld_p1;

endmodule

// File: tb/tb_rmt_axis_pkt_arb.sv
// ---------------------------------------------------------------------------
// tb_rmt_axis_pkt_arb
// Directed bench for rmt_axis_pkt_arb (4 channels, 512-bit data).
// Each channel's beats carry a pattern built from {channel, packet, beat};
// expected output order and timing are written per cycle by hand.
// Inputs change on the falling edge; outputs are read there too.
// ---------------------------------------------------------------------------
module tb_rmt_axis_pkt_arb;

  localparam int NCH = 4;
  localparam int DW  = 512;
  localparam int KW  = 64;
  localparam int UW  = 128;

  logic                 clk = 1'b0;
  logic                 aresetn;
  logic [NCH*DW-1:0]    s_tdata;
  logic [NCH*KW-1:0]    s_tkeep;
  logic [NCH*UW-1:0]    s_tuser;
  logic [NCH-1:0]       s_tvalid;
  logic [NCH-1:0]       s_tlast;
  logic [NCH-1:0]       s_tready;
  logic [DW-1:0]        m_tdata;
  logic [KW-1:0]        m_tkeep;
  logic [UW-1:0]        m_tuser;
  logic                 m_tvalid;
  logic                 m_tlast;
  logic                 m_tready;
  logic [1:0]           cur_grant;
  logic [31:0]          pkt_cnt;

  int total = 0;
  int bad   = 0;

  int len[NCH];
  int bi[NCH];
  int pk[NCH];
  int rem[NCH];

  always #5 clk = ~clk;

  rmt_axis_pkt_arb dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .cur_grant     (cur_grant),
    .pkt_cnt       (pkt_cnt)
  );

  function automatic logic [15:0] bword(int ch, int pkt, int beat);
    return {4'hA, 4'(ch), 4'(pkt), 4'(beat)};
  endfunction

  function automatic logic [DW-1:0] bdata(int ch, int pkt, int beat);
    return {32{bword(ch, pkt, beat)}};
  endfunction

  function automatic logic [KW-1:0] bkeep(int ch, int pkt, int beat);
    return {4{bword(ch, pkt, beat)}};
  endfunction

  function automatic logic [UW-1:0] buser(int ch, int pkt, int beat);
    return {8{~bword(ch, pkt, beat)}};
  endfunction

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(string tag, int ch, int pkt, int beat, int last);
    chk({tag, ".vld"},  DW'(m_tvalid), DW'(1));
    chk({tag, ".data"}, m_tdata, bdata(ch, pkt, beat));
    chk({tag, ".keep"}, DW'(m_tkeep), DW'(bkeep(ch, pkt, beat)));
    chk({tag, ".user"}, DW'(m_tuser), DW'(buser(ch, pkt, beat)));
    chk({tag, ".last"}, DW'(m_tlast), DW'(last));
  endtask

  task automatic exp_idle(string tag);
    chk({tag, ".vld"}, DW'(m_tvalid), DW'(0));
  endtask

  task automatic drive();
    for (int c = 0; c < NCH; c++) begin
      s_tdata[c*DW +: DW] = bdata(c, pk[c], bi[c]);
      s_tkeep[c*KW +: KW] = bkeep(c, pk[c], bi[c]);
      s_tuser[c*UW +: UW] = buser(c, pk[c], bi[c]);
      s_tvalid[c]         = (len[c] != 0);
      s_tlast[c]          = (len[c] != 0) && (bi[c] == len[c] - 1);
    end
  endtask

  // Present `n` packets of `l` beats each on channel `ch`.
  task automatic start(int ch, int l, int n);
    len[ch] = l;
    bi[ch]  = 0;
    pk[ch]  = 0;
    rem[ch] = n;
    drive();
    #1;
  endtask

  task automatic clear_all();
    for (int c = 0; c < NCH; c++) begin
      len[c] = 0; bi[c] = 0; pk[c] = 0; rem[c] = 0;
    end
    drive();
  endtask

  // Advance one clock: note which channels handshake at the coming rising
  // edge, then at the falling edge move those channels to their next beat.
  task automatic step();
    logic [NCH-1:0] accd;
    accd = s_tvalid & s_tready;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (accd[c]) begin
        bi[c]++;
        if (bi[c] == len[c]) begin
          bi[c] = 0;
          pk[c]++;
          rem[c]--;
          if (rem[c] == 0) len[c] = 0;
        end
      end
    end
    drive();
    #1;
  endtask

  int exp_ch[4];
  int exp_pk[4];

  initial begin
    aresetn  = 1'b0;
    m_tready = 1'b1;
    clear_all();

    // ---- reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.m_valid", DW'(m_tvalid), DW'(0));
    chk("rst.m_data",  m_tdata, DW'(0));
    chk("rst.m_last",  DW'(m_tlast), DW'(0));
    chk("rst.pkt_cnt", DW'(pkt_cnt), DW'(0));
    chk("rst.grant",   DW'(cur_grant), DW'(0));
    chk("rst.s_ready", DW'(s_tready), DW'(0));
    aresetn = 1'b1;

    // ---- simultaneous 2-beat packets on ch0, ch2, ch3 from rr_ptr=0
    start(0, 2, 1); start(2, 2, 1); start(3, 2, 1);
    chk("sim.idle_rdy", DW'(s_tready), DW'(0));
    step(); chk("sim.g0", DW'(cur_grant), DW'(0)); chk("sim.r0", DW'(s_tready), DW'(4'b0001)); exp_idle("sim.i0");
    step(); exp_out("sim.c0b0", 0, 0, 0, 0); chk("sim.r0b", DW'(s_tready), DW'(4'b0001));
    step(); exp_out("sim.c0b1", 0, 0, 1, 1); chk("sim.bub0", DW'(s_tready), DW'(0)); chk("sim.cnt1", DW'(pkt_cnt), DW'(1));
    step(); exp_idle("sim.i2"); chk("sim.g2", DW'(cur_grant), DW'(2)); chk("sim.r2", DW'(s_tready), DW'(4'b0100));
    step(); exp_out("sim.c2b0", 2, 0, 0, 0);
    step(); exp_out("sim.c2b1", 2, 0, 1, 1); chk("sim.bub2", DW'(s_tready), DW'(0));
    step(); exp_idle("sim.i3"); chk("sim.g3", DW'(cur_grant), DW'(3)); chk("sim.r3", DW'(s_tready), DW'(4'b1000));
    step(); exp_out("sim.c3b0", 3, 0, 0, 0);
    step(); exp_out("sim.c3b1", 3, 0, 1, 1); chk("sim.cnt3", DW'(pkt_cnt), DW'(3));
    step(); exp_idle("sim.end"); chk("sim.rr", DW'(dut.rr_ptr), DW'(0));

    // ---- single channel: ch1, 4 beats
    start(1, 4, 1);
    step(); chk("one.g", DW'(cur_grant), DW'(1)); chk("one.r", DW'(s_tready), DW'(4'b0010)); exp_idle("one.i");
    step(); exp_out("one.b0", 1, 0, 0, 0);
    step(); exp_out("one.b1", 1, 0, 1, 0);
    step(); exp_out("one.b2", 1, 0, 2, 0);
    step(); exp_out("one.b3", 1, 0, 3, 1); chk("one.cnt", DW'(pkt_cnt), DW'(4)); chk("one.r_end", DW'(s_tready), DW'(0));
    step(); exp_idle("one.end");

    // ---- backpressure: ch2, 4 beats, m_tready 1,0,0,1
    start(2, 4, 1);
    step(); chk("bp.g", DW'(cur_grant), DW'(2)); chk("bp.r", DW'(s_tready), DW'(4'b0100));
    step(); exp_out("bp.b0", 2, 0, 0, 0);
    m_tready = 1'b0; #1;
    chk("bp.stall_r0", DW'(s_tready), DW'(0));
    step(); exp_out("bp.hold1", 2, 0, 0, 0); chk("bp.stall_r1", DW'(s_tready), DW'(0));
    step(); exp_out("bp.hold2", 2, 0, 0, 0);
    m_tready = 1'b1; #1;
    chk("bp.resume_r", DW'(s_tready), DW'(4'b0100));
    step(); exp_out("bp.b1", 2, 0, 1, 0);
    step(); exp_out("bp.b2", 2, 0, 2, 0);
    step(); exp_out("bp.b3", 2, 0, 3, 1); chk("bp.cnt", DW'(pkt_cnt), DW'(5));
    step(); exp_idle("bp.end");

    // ---- alternating single-beat packets on ch0/ch1 (rr_ptr=3 -> ch0 first)
    start(0, 1, 5); start(1, 1, 5);
    step(); chk("alt.g_first", DW'(cur_grant), DW'(0)); chk("alt.r_first", DW'(s_tready), DW'(4'b0001));
    for (int k = 0; k < 10; k++) begin
      step();
      exp_out($sformatf("alt.p%0d", k), k % 2, k / 2, 0, 1);
      chk($sformatf("alt.arb_r%0d", k), DW'(s_tready), DW'(0));
      step();
      exp_idle($sformatf("alt.bub%0d", k));
      if (k < 9) begin
        chk($sformatf("alt.g%0d", k + 1), DW'(cur_grant), DW'((k + 1) % 2));
        chk($sformatf("alt.r%0d", k + 1), DW'(s_tready), DW'(1 << ((k + 1) % 2)));
      end
    end
    chk("alt.cnt", DW'(pkt_cnt), DW'(15));

    // ---- ch0 and ch2 both requesting with rr_ptr=2
`ifdef RMT_ARB_CTRL_PRIO_EN
    exp_ch = '{0, 0, 2, 2};
    exp_pk = '{0, 1, 0, 1};
`else
    exp_ch = '{2, 0, 2, 0};
    exp_pk = '{0, 0, 1, 1};
`endif
    start(0, 1, 2); start(2, 1, 2);
    step(); chk("pri.g_first", DW'(cur_grant), DW'(exp_ch[0]));
    for (int k = 0; k < 4; k++) begin
      step();
      exp_out($sformatf("pri.p%0d", k), exp_ch[k], exp_pk[k], 0, 1);
      step();
      exp_idle($sformatf("pri.bub%0d", k));
      if (k < 3) chk($sformatf("pri.g%0d", k + 1), DW'(cur_grant), DW'(exp_ch[k + 1]));
    end
    chk("pri.cnt", DW'(pkt_cnt), DW'(19));

    // ---- reset on beat 2 of a 4-beat ch3 packet
    start(3, 4, 1);
    step(); chk("rmp.g", DW'(cur_grant), DW'(3));
    step(); exp_out("rmp.b0", 3, 0, 0, 0);
    step(); exp_out("rmp.b1", 3, 0, 1, 0);
    aresetn = 1'b0; #1;
    chk("rmp.vld", DW'(m_tvalid), DW'(0));
    chk("rmp.data", m_tdata, DW'(0));
    chk("rmp.cnt", DW'(pkt_cnt), DW'(0));
    chk("rmp.g0", DW'(cur_grant), DW'(0));
    chk("rmp.r", DW'(s_tready), DW'(0));
    clear_all();
    step();
    aresetn = 1'b1;
    start(0, 1, 1); start(3, 1, 1);
    step(); chk("rmp.ng", DW'(cur_grant), DW'(0)); chk("rmp.nr", DW'(s_tready), DW'(4'b0001));
    step(); exp_out("rmp.n0", 0, 0, 0, 1); chk("rmp.ncnt1", DW'(pkt_cnt), DW'(1));
    step(); chk("rmp.ng3", DW'(cur_grant), DW'(3));
    step(); exp_out("rmp.n3", 3, 0, 0, 1); chk("rmp.ncnt2", DW'(pkt_cnt), DW'(2));
    step(); exp_idle("rmp.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
